mock_uart_tx: RTL

MOCK_UART_TX -- requirements
Module: mock_uart_tx

---
 rtl/mock_uart_tx.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mock_uart_tx.sv
// UART transmitter mock with a byte FIFO, driving the SoC uart_rx line.
// Optional inter-frame idle gap enabled by defining MOCK_UART_TX_IDLE_GAP_EN.
module mock_uart_tx #(
  parameter int BaudRate     = 115200,
  parameter int ClockFreqHz  = 50000000,
  parameter int ParityBit    = 0,
  parameter int DataBitsSize = 8,
  parameter int StopBitsSize = 1,
  parameter int BufferSize   = 128,
  parameter int IdleGapBits  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_valid,
  input  logic [7:0]                      wr_data,
  output logic                            wr_ready,
  output logic                            tx_sig,
  output logic                            busy,
  output logic                            tx_done,
  output logic [$clog2(BufferSize+1)-1:0] level
);

  localparam int ClksPerBit = ClockFreqHz / BaudRate;
  localparam int CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int LvlW       = $clog2(BufferSize + 1);
  localparam int PtrW       = $clog2(BufferSize);
`ifdef MOCK_UART_TX_IDLE_GAP_EN
  localparam int GapCycles  = IdleGapBits * ClksPerBit;
  localparam int GapW       = (GapCycles > 1) ? $clog2(GapCycles) : 1;
`endif

  if (ClksPerBit < 1) begin : g_chk_baud
    $error("mock_uart_tx: ClockFreqHz/BaudRate must be at least 1");
  end
  if (DataBitsSize < 5 || DataBitsSize > 8) begin : g_chk_data
    $error("mock_uart_tx: DataBitsSize must be 5..8");
  end
  if (StopBitsSize < 1 || StopBitsSize > 2) begin : g_chk_stop
    $error("mock_uart_tx: StopBitsSize must be 1..2");
  end
  if (BufferSize < 2) begin : g_chk_buf
    $error("mock_uart_tx: BufferSize must be at least 2");
  end
  if (ParityBit < 0 || ParityBit > 1 || IdleGapBits < 0) begin : g_chk_misc
    $error("mock_uart_tx: ParityBit must be 0/1 and IdleGapBits non-negative");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef MOCK_UART_TX_IDLE_GAP_EN
    , GAP
`endif
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [DataBitsSize-1:0] mem_q [BufferSize];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]         level_q;
  state_e                  state_q, state_d;
  logic                    push, pop;

  assign wr_ready = (level_q != LvlW'(BufferSize));
  assign push     = wr_valid && wr_ready;
  assign pop      = (state_q == IDLE) && (level_q != '0);
  assign level    = level_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufferSize - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is not reset; pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= wr_data[DataBitsSize-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- framer
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [DataBitsSize-1:0] shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bit_end;
`ifdef MOCK_UART_TX_IDLE_GAP_EN
  logic [GapW-1:0]         gap_q, gap_d;
`endif

  assign bit_end = (cnt_q == CntW'(ClksPerBit - 1));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
`ifdef MOCK_UART_TX_IDLE_GAP_EN
    gap_d    = gap_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (level_q != '0) begin
          shift_d  = mem_q[rd_ptr_q];
          parity_d = ^mem_q[rd_ptr_q];
          state_d  = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'(DataBitsSize - 1)) begin
            idx_d   = '0;
            state_d = (ParityBit != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (idx_q == 3'(StopBitsSize - 1)) begin
            idx_d = '0;
`ifdef MOCK_UART_TX_IDLE_GAP_EN
            gap_d   = '0;
            state_d = (GapCycles > 0) ? GAP : IDLE;
`else
            state_d = IDLE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef MOCK_UART_TX_IDLE_GAP_EN
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GapW'(GapCycles - 1)) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Line outputs are registered, so they trail the state by one cycle.
    unique case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = parity_q;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE);
    done_d = (state_q == STOP) && bit_end && (idx_q == 3'(StopBitsSize - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MOCK_UART_TX_IDLE_GAP_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MOCK_UART_TX_IDLE_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

  assign tx_sig  = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
